// File: rtl/parking_pkg.sv
// parking_pkg: shared state encoding and default limits for the parking gate controller
package parking_pkg;
  typedef enum logic [3:0] {
    IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A, DENY, CLEAR
  } state_t;
  localparam int CAPACITY_DEF = 200;
  localparam int TIMEOUT_DEF  = 1000;
  function automatic logic gate_state(state_t s);
    return s inside {EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A};
  endfunction
endpackage

// File: rtl/parking_sensor_sync.sv
// parking_sensor_sync: two-flop synchroniser for one beam sensor, plus optional debounce
// Ports: clk, reset (async active-low), raw (asynchronous sensor), filt (clean level)
// Debounce only when PARK_DEBOUNCE_EN is defined; filt then follows after DEBOUNCE_CYC equal samples.
module parking_sensor_sync
`ifdef PARK_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYC = 4)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  logic s1, s2;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s2, s1} <= 2'b00;
    else        {s2, s1} <= {s1, raw};
`ifdef PARK_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic [DW-1:0] cnt;
  logic f;
  // any sample that agrees with the held level restarts the run, so short glitches never commit
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      f   <= 1'b0;
    end else if (s2 == f) cnt <= '0;
    else if (cnt == DW'(DEBOUNCE_CYC - 1)) begin
      f   <= s2;
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
  assign filt = f;
`else
  assign filt = s2;
`endif
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: decodes beam order into entry/exit pulses and drives the barrier gate
// Ports: clk, reset (async active-low), a/b (outer/inner beams, async), count (occupancy),
//        inc/dec/deny (one-cycle pulses), gate_open, full (count >= CAPACITY, registered), busy
// Optional: PARK_DEBOUNCE_EN adds a DEBOUNCE_CYC-sample filter behind each synchroniser.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int CAPACITY    = CAPACITY_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
`ifdef PARK_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYC = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic [CNT_W-1:0] count,
  output logic             inc,
  output logic             dec,
  output logic             gate_open,
  output logic             full,
  output logic             deny,
  output logic             busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic sa, sb;
  logic [1:0] ab;
  state_t state, nxt;
  logic [TW-1:0] tmr;
  logic hit, nxt_inc, nxt_dec, nxt_deny;
`ifdef PARK_DEBOUNCE_EN
  parking_sensor_sync #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sync_a (.clk(clk), .reset(reset), .raw(a), .filt(sa));
  parking_sensor_sync #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sync_b (.clk(clk), .reset(reset), .raw(b), .filt(sb));
`else
  parking_sensor_sync u_sync_a (.clk(clk), .reset(reset), .raw(a), .filt(sa));
  parking_sensor_sync u_sync_b (.clk(clk), .reset(reset), .raw(b), .filt(sb));
`endif
  assign ab   = {sa, sb};
  assign hit  = tmr == TW'(TIMEOUT_CYC);
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: case (ab)
        2'b10:   nxt = full ? DENY : EN_A;
        2'b01:   nxt = EX_B;
        2'b11:   nxt = CLEAR;
        default: nxt = IDLE;
      endcase
      EN_A:    nxt = ab == 2'b11 ? EN_AB : ab == 2'b00 ? IDLE  : EN_A;
      EN_AB:   nxt = ab == 2'b01 ? EN_B  : ab == 2'b10 ? EN_A  : EN_AB;
      EN_B:    nxt = ab == 2'b00 ? IDLE  : ab == 2'b11 ? EN_AB : EN_B;
      EX_B:    nxt = ab == 2'b11 ? EX_BA : ab == 2'b00 ? IDLE  : EX_B;
      EX_BA:   nxt = ab == 2'b10 ? EX_A  : ab == 2'b01 ? EX_B  : EX_BA;
      EX_A:    nxt = ab == 2'b00 ? IDLE  : ab == 2'b11 ? EX_BA : EX_A;
      default: nxt = ab == 2'b00 ? IDLE  : state;
    endcase
    // CLEAR is exempt so a saturated timer cannot pin it away from IDLE
    if (hit && !(state inside {IDLE, CLEAR})) nxt = CLEAR;
    nxt_inc  = state == EN_B && nxt == IDLE;
    nxt_dec  = state == EX_A && nxt == IDLE && count != '0;
    nxt_deny = state == IDLE && nxt == DENY;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      tmr       <= '0;
      inc       <= 1'b0;
      dec       <= 1'b0;
      deny      <= 1'b0;
      gate_open <= 1'b0;
      full      <= 1'b0;
    end else begin
      state     <= nxt;
      tmr       <= nxt != state ? '0 : (state != IDLE && !hit) ? tmr + 1'b1 : tmr;
      inc       <= nxt_inc;
      dec       <= nxt_dec;
      deny      <= nxt_deny;
      gate_open <= gate_state(nxt);
      full      <= 32'(count) >= 32'(CAPACITY);
    end
endmodule
